// File: rtl/arith_pkg.sv
// Shared arithmetic-lab definitions: serial FSM state encoding and the default
// operand width used by both the ripple adder and the serial subtractor.
`timescale 1ns/1ps
package arith_pkg;

  localparam int ARITH_W = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/full_sub_1.sv
// One-bit combinational full-subtractor cell: d = a - b - bin, with borrow out.
`timescale 1ns/1ps
module full_sub_1 (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~a & bin) | (b & bin);

endmodule

// File: rtl/sub_serial_4.sv
// Bit-serial subtractor, LSB first, one full_sub_1 cell reused every cycle.
// Optional zero-result flag output when SUB_ZERO_FLAG_EN is defined.
`timescale 1ns/1ps
module sub_serial_4
  import arith_pkg::*;
#(
  parameter int N = ARITH_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         symbol,
  output logic [N-1:0] diff,
  output logic         borrow,
  output logic         overflow,
  output logic         busy,
`ifdef SUB_ZERO_FLAG_EN
  output logic         done,
  output logic         zero
`else
  output logic         done
`endif
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t        state, state_nx;
  logic [N-1:0]  a_q, b_q;
  logic          sym_q;
  logic [CW-1:0] cnt;
  logic          br;
  logic          d_bit, bout_bit;

  full_sub_1 u_cell (
    .a    (a_q[cnt]),
    .b    (b_q[cnt]),
    .bin  (br),
    .d    (d_bit),
    .bout (bout_bit)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    // NOTE: default assigned first so every path drives state_nx and no latch is inferred.
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = S_SHIFT;
      S_SHIFT: if (cnt == LAST) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Results are overwritten bit by bit during SHIFT and otherwise hold.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      sym_q    <= 1'b0;
      cnt      <= '0;
      br       <= 1'b0;
      diff     <= '0;
      borrow   <= 1'b0;
      overflow <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
`ifdef SUB_ZERO_FLAG_EN
      zero     <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            a_q   <= a;
            b_q   <= b;
            sym_q <= symbol;
            br    <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        S_SHIFT: begin
          diff[cnt] <= d_bit;
          br        <= bout_bit;
          cnt       <= cnt + CW'(1);
        end
        S_DONE: begin
          done     <= 1'b1;
          busy     <= 1'b0;
          borrow   <= br;
          overflow <= sym_q & (a_q[N-1] ^ b_q[N-1]) & (diff[N-1] ^ a_q[N-1]);
`ifdef SUB_ZERO_FLAG_EN
          zero     <= (diff == '0);
`endif
        end
        default: ;
      endcase
    end
  end

endmodule
